// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and the operand forwarding-source encoding.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 16;

  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EX   = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_fetch_mux.sv
// Resolves one source operand: x0, EX bypass, WB bypass, or register file read.
module operand_mux
  import core_pkg::*;
#(
  parameter int N = XLEN,
  parameter int A = REG_ADDR_W
) (
  input  logic [A-1:0] i_rs,
  input  logic [N-1:0] i_rf_data,
  input  logic         i_ex_valid,
  input  logic         i_ex_pending,
  input  logic [A-1:0] i_ex_rd,
  input  logic [N-1:0] i_ex_data,
  input  logic         i_wb_we,
  input  logic [A-1:0] i_wb_rd,
  input  logic [N-1:0] i_wb_data,
  output logic [N-1:0] o_val
);

  fwd_sel_e w_sel;

  // Source priority: x0, then the younger EX result, then the WB write in flight.
  always_comb begin
    w_sel = FWD_RF;
    if (i_rs == {A{1'b0}}) begin
      w_sel = FWD_ZERO;
    end else if (i_ex_valid && !i_ex_pending && (i_ex_rd == i_rs)) begin
      w_sel = FWD_EX;
    end else if (i_wb_we && (i_wb_rd == i_rs)) begin
      w_sel = FWD_WB;
    end else begin
      w_sel = FWD_RF;
    end
  end

  always_comb begin
    o_val = {N{1'b0}};
    case (w_sel)
      FWD_ZERO: o_val = {N{1'b0}};
      FWD_EX:   o_val = i_ex_data;
      FWD_WB:   o_val = i_wb_data;
      FWD_RF:   o_val = i_rf_data;
      default:  o_val = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute stage: register file reads, EX/WB forwarding, load-use stall,
// and a registered operand bundle behind a valid/ready handshake.
module operand_fetch
  import core_pkg::*;
#(
  parameter int N = XLEN,
  parameter int A = $clog2(N),
  parameter int C = CTRL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [A-1:0] in_rs1,
  input  logic [A-1:0] in_rs2,
  input  logic [A-1:0] in_rd,
  input  logic         in_use_rs1,
  input  logic         in_use_rs2,
  input  logic         in_rd_we,
  input  logic [N-1:0] in_pc,
  input  logic [N-1:0] in_imm,
  input  logic [C-1:0] in_ctrl,
  output logic [A-1:0] addr1,
  output logic [A-1:0] addr2,
  input  logic [N-1:0] rd1,
  input  logic [N-1:0] rd2,
  input  logic         ex_fwd_valid,
  input  logic         ex_fwd_pending,
  input  logic [A-1:0] ex_fwd_rd,
  input  logic [N-1:0] ex_fwd_data,
  input  logic         wb_we,
  input  logic [A-1:0] wb_rd,
  input  logic [N-1:0] wb_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_rs1_val,
  output logic [N-1:0] out_rs2_val,
  output logic [A-1:0] out_rd,
  output logic         out_rd_we,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_imm,
  output logic [C-1:0] out_ctrl,
  output logic [31:0]  stall_cycles
);

  logic         w_hazard;
  logic         w_capture;
  logic [N-1:0] w_rs1_val;
  logic [N-1:0] w_rs2_val;

  logic         r_out_valid;
  logic [N-1:0] r_rs1_val;
  logic [N-1:0] r_rs2_val;
  logic [A-1:0] r_rd;
  logic         r_rd_we;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_imm;
  logic [C-1:0] r_ctrl;
  logic [31:0]  r_stall;

  assign addr1 = in_rs1;
  assign addr2 = in_rs2;

  operand_mux #(.N(N), .A(A)) u_mux_rs1 (
    .i_rs(in_rs1), .i_rf_data(rd1),
    .i_ex_valid(ex_fwd_valid), .i_ex_pending(ex_fwd_pending),
    .i_ex_rd(ex_fwd_rd), .i_ex_data(ex_fwd_data),
    .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_val(w_rs1_val)
  );

  operand_mux #(.N(N), .A(A)) u_mux_rs2 (
    .i_rs(in_rs2), .i_rf_data(rd2),
    .i_ex_valid(ex_fwd_valid), .i_ex_pending(ex_fwd_pending),
    .i_ex_rd(ex_fwd_rd), .i_ex_data(ex_fwd_data),
    .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_val(w_rs2_val)
  );

  // Load-use hazard: only operands actually read stall, and x0 never does.
  always_comb begin
    w_hazard = 1'b0;
    if (in_valid && ex_fwd_valid && ex_fwd_pending && (ex_fwd_rd != {A{1'b0}})) begin
      w_hazard = (in_use_rs1 && (in_rs1 == ex_fwd_rd)) ||
                 (in_use_rs2 && (in_rs2 == ex_fwd_rd));
    end else begin
      w_hazard = 1'b0;
    end
  end

  assign in_ready  = (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_capture = in_valid && in_ready;

  // Bundle register: flush drops the held bundle; operands freeze at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_rs1_val   <= {N{1'b0}};
      r_rs2_val   <= {N{1'b0}};
      r_rd        <= {A{1'b0}};
      r_rd_we     <= 1'b0;
      r_pc        <= {N{1'b0}};
      r_imm       <= {N{1'b0}};
      r_ctrl      <= {C{1'b0}};
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_rs1_val   <= w_rs1_val;
      r_rs2_val   <= w_rs2_val;
      r_rd        <= in_rd;
      r_rd_we     <= in_rd_we;
      r_pc        <= in_pc;
      r_imm       <= in_imm;
      r_ctrl      <= in_ctrl;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Saturating count of cycles spent stalled on a load-use hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= 32'd0;
    end else if (w_hazard && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end else begin
      r_stall <= r_stall;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_rs1_val  = r_rs1_val;
  assign out_rs2_val  = r_rs2_val;
  assign out_rd       = r_rd;
  assign out_rd_we    = r_rd_we;
  assign out_pc       = r_pc;
  assign out_imm      = r_imm;
  assign out_ctrl     = r_ctrl;
  assign stall_cycles = r_stall;

endmodule
